// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
//   Shared definitions for the intersection light controllers (fixed-time and
//   demand-driven): light codes, phase encodings, controller state encoding
//   and small helpers.
// -----------------------------------------------------------------------------
package tlc_pkg;

  // Per-approach light codes (pedestrian head: walk / flashing / don't-walk).
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_RED = 3'b100;

  // Phase encodings; the value is also the bit index in req/pend.
  localparam logic [1:0] PH_M  = 2'd0;  // main through
  localparam logic [1:0] PH_MT = 2'd1;  // main turn
  localparam logic [1:0] PH_S  = 2'd2;  // side street
  localparam logic [1:0] PH_P  = 2'd3;  // pedestrian

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } tlc_state_t;

  function automatic logic [3:0] phase_onehot(input logic [1:0] ph);
    return 4'b0001 << ph;
  endfunction

  // Light shown by the owning approach in a given controller state.
  function automatic logic [2:0] owner_light(input tlc_state_t st);
    case (st)
      ST_GREEN:  return LT_GRN;
      ST_YELLOW: return LT_YEL;
      default:   return LT_RED;
    endcase
  endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// -----------------------------------------------------------------------------
// tlc_phase_scheduler_if
//   Signal bundle between the phase scheduler and its environment.
//   req[3:0]       phase requests ([0] M, [1] MT, [2] S, [3] P)
//   light_M/MT/S/P 3-bit light codes per approach
//   phase          phase owning (or last owning) right-of-way
//   phase_start    one-cycle pulse on the first cycle of a new green
//   preempt        emergency preemption request   (TLC_PREEMPT_EN only)
//   preempt_act    registered preemption status   (TLC_PREEMPT_EN only)
//   Modports: slave = scheduler side, master = request/monitor side.
//   Optional feature macro: TLC_PREEMPT_EN.
// -----------------------------------------------------------------------------
interface tlc_phase_scheduler_if;

  logic [3:0] req;
  logic [2:0] light_M;
  logic [2:0] light_MT;
  logic [2:0] light_S;
  logic [2:0] light_P;
  logic [1:0] phase;
  logic       phase_start;
`ifdef TLC_PREEMPT_EN
  logic       preempt;
  logic       preempt_act;

  modport slave (
    input  req, preempt,
    output light_M, light_MT, light_S, light_P, phase, phase_start, preempt_act
  );
  modport master (
    output req, preempt,
    input  light_M, light_MT, light_S, light_P, phase, phase_start, preempt_act
  );
`else
  modport slave (
    input  req,
    output light_M, light_MT, light_S, light_P, phase, phase_start
  );
  modport master (
    output req,
    input  light_M, light_MT, light_S, light_P, phase, phase_start
  );
`endif

endinterface

// File: rtl/tlc_rr_pick.sv
// -----------------------------------------------------------------------------
// tlc_rr_pick
//   Combinational 4-way round-robin picker. Searches pend starting at the
//   phase after the current one (phase+1, +2, +3, modulo 4); the current
//   phase itself is never picked.
//   pend  in  4  pending requests
//   phase in  2  current phase
//   next  out 2  chosen phase (PH_M when nothing pending)
//   valid out 1  a pending phase was found
// -----------------------------------------------------------------------------
module tlc_rr_pick
  import tlc_pkg::*;
(
  input  logic [3:0] pend,
  input  logic [1:0] phase,
  output logic [1:0] next,
  output logic       valid
);

  always_comb begin
    logic [1:0] idx;
    next  = PH_M;
    valid = 1'b0;
    idx   = '0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = 3; k >= 1; k--) begin
      idx = phase + 2'(k);
      if (pend[idx]) begin
        next  = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tlc_phase_scheduler
//   Demand-driven phase scheduler. Latches requests, grants one green phase
//   at a time in round-robin order with min/max green, yellow and all-red
//   clearance timing, and drives registered per-approach light codes.
//   Ports:
//     clk  clock
//     rst  asynchronous active-high reset
//     bus  tlc_phase_scheduler_if.slave (requests in, lights/phase out)
//   Optional feature macro: TLC_PREEMPT_EN (emergency preemption to phase M).
// -----------------------------------------------------------------------------
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int TW        = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  tlc_phase_scheduler_if.slave   bus
);

  tlc_state_t    st_reg, st_next;
  logic [1:0]    phase_reg, phase_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [3:0]    pend_reg, pend_next, pend_set;
  logic          start_reg, start_next;
  logic [11:0]   lights_reg, lights_next;
  logic          others;
  logic          go;
  logic [1:0]    pick_next;
  logic          pick_valid;

  // A request for the phase that is currently green extends that green
  // rather than queueing another service of it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pend
      assign pend_set[gi] = pend_reg[gi] |
        (bus.req[gi] & ~((st_reg == ST_GREEN) && (phase_reg == 2'(gi))));
    end
  endgenerate

  assign others = |(pend_reg & ~phase_onehot(phase_reg));

  // Picker sees same-cycle arrivals so a request landing on the last
  // all-red cycle is still served next.
  tlc_rr_pick u_pick (
    .pend  (pend_set),
    .phase (phase_reg),
    .next  (pick_next),
    .valid (pick_valid)
  );

  always_comb begin
    st_next    = st_reg;
    phase_next = phase_reg;
    pend_next  = pend_set;
    start_next = 1'b0;
    go         = 1'b0;
    case (st_reg)
      ST_GREEN: begin
        go = others && (timer_reg >= TW'(MIN_GREEN - 1)) &&
             (!bus.req[phase_reg] || (timer_reg >= TW'(MAX_GREEN - 1)));
`ifdef TLC_PREEMPT_EN
        // Preemption cuts any non-M green short and pins M green.
        if (bus.preempt) go = (phase_reg != PH_M);
`endif
        if (go) st_next = ST_YELLOW;
      end
      ST_YELLOW: begin
        go = (timer_reg >= TW'(YELLOW_T - 1));
        if (go) st_next = ST_ALLRED;
      end
      ST_ALLRED: begin
        go = (timer_reg >= TW'(ALLRED_T - 1));
        if (go) begin
          st_next    = ST_GREEN;
          phase_next = pick_valid ? pick_next : PH_M;
`ifdef TLC_PREEMPT_EN
          if (bus.preempt) phase_next = PH_M;
`endif
          // Entering green consumes the request; clear beats a new req.
          pend_next  = pend_set & ~phase_onehot(phase_next);
          start_next = 1'b1;
        end
      end
      default: begin
        st_next = ST_GREEN;
        go      = 1'b1;
      end
    endcase
    timer_next = go ? '0 : ((&timer_reg) ? timer_reg : timer_reg + 1'b1);
  end

  // Lights are decoded from the next state so they change together with
  // the state register.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_light
      assign lights_next[gi*3 +: 3] =
        (phase_next == 2'(gi)) ? owner_light(st_next) : LT_RED;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_reg     <= ST_GREEN;
      phase_reg  <= PH_M;
      timer_reg  <= '0;
      pend_reg   <= '0;
      start_reg  <= 1'b0;
      lights_reg <= {LT_RED, LT_RED, LT_RED, LT_GRN};
    end else begin
      st_reg     <= st_next;
      phase_reg  <= phase_next;
      timer_reg  <= timer_next;
      pend_reg   <= pend_next;
      start_reg  <= start_next;
      lights_reg <= lights_next;
    end
  end

`ifdef TLC_PREEMPT_EN
  logic preempt_act_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) preempt_act_reg <= 1'b0;
    else     preempt_act_reg <= bus.preempt;
  end
  assign bus.preempt_act = preempt_act_reg;
`endif

  assign bus.light_M     = lights_reg[2:0];
  assign bus.light_MT    = lights_reg[5:3];
  assign bus.light_S     = lights_reg[8:6];
  assign bus.light_P     = lights_reg[11:9];
  assign bus.phase       = phase_reg;
  assign bus.phase_start = start_reg;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tlc_phase_scheduler
//   Self-checking bench for tlc_phase_scheduler (default parameters).
//   A cycle model pushes the expected registered outputs for every driven
//   cycle; they are popped and compared one clock later. Directed checks
//   cover the reset, max-out/gap-out, round-robin and async-reset cases.
// -----------------------------------------------------------------------------
module tb_tlc_phase_scheduler;
  import tlc_pkg::*;

  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int YEL_T = 3;
  localparam int AR_T  = 2;

  typedef struct packed {
    logic [11:0] lights;
    logic [1:0]  ph;
    logic        start;
    logic        act;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  int   starts = 0;
  logic p_yel_seen = 1'b0;

  exp_t sb[$];

  // model state
  int         m_st, m_ph, m_tmr;
  logic [3:0] m_pend;
`ifdef TLC_PREEMPT_EN
  logic pre_drv = 1'b0;
`endif

  tlc_phase_scheduler_if bus ();

  tlc_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_tmr = 0; m_pend = 4'b0000;
    sb.delete();
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oh, set;
    logic       others, go, start, p;
    int         np;
    exp_t       e;
    p = 1'b0;
`ifdef TLC_PREEMPT_EN
    p = pre_drv;
`endif
    oh     = 4'b0001 << m_ph;
    others = |(m_pend & ~oh);
    set    = m_pend | (r & ((m_st == 0) ? ~oh : 4'b1111));
    go     = 1'b0;
    start  = 1'b0;
    np     = m_ph;
    case (m_st)
      0: begin
        go = others && (m_tmr >= MIN_G - 1) && (!r[m_ph] || (m_tmr >= MAX_G - 1));
        if (p) go = (m_ph != 0);
      end
      1:       go = (m_tmr >= YEL_T - 1);
      default: go = (m_tmr >= AR_T - 1);
    endcase
    if (go && m_st == 2) begin
      np = 0;
      for (int k = 3; k >= 1; k--)
        if (set[(m_ph + k) % 4]) np = (m_ph + k) % 4;
      if (p) np = 0;
      set[np] = 1'b0;
      start = 1'b1;
    end
    m_pend = set;
    m_ph   = np;
    m_tmr  = go ? 0 : ((m_tmr < 255) ? m_tmr + 1 : m_tmr);
    m_st   = go ? (m_st + 1) % 3 : m_st;
    for (int a = 0; a < 4; a++)
      e.lights[a*3 +: 3] = (a == m_ph) ? ((m_st == 0) ? LT_GRN : (m_st == 1) ? LT_YEL : LT_RED) : LT_RED;
    e.ph    = 2'(m_ph);
    e.start = start;
    e.act   = p;
    sb.push_back(e);
  endtask

  // One clock: drive inputs, predict, then compare after the edge.
  task automatic cyc(input logic [3:0] r);
    exp_t e;
    bus.req = r;
`ifdef TLC_PREEMPT_EN
    bus.preempt = pre_drv;
`endif
    model_step(r);
    @(posedge clk);
    #1;
    cyc_n++;
    e = sb.pop_front();
    chk("lights", {bus.light_P, bus.light_S, bus.light_MT, bus.light_M}, e.lights);
    chk("phase", bus.phase, e.ph);
    chk("phase_start", bus.phase_start, e.start);
`ifdef TLC_PREEMPT_EN
    chk("preempt_act", bus.preempt_act, e.act);
`endif
    if (bus.light_P == LT_YEL) p_yel_seen = 1'b1;
    if (bus.phase_start) begin
      starts++;
      $display("cycle %0d: green start phase %0d", cyc_n, bus.phase);
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    do begin
      cyc(4'b0000);
      n++;
    end while (!bus.phase_start && n < 40);
    if (!bus.phase_start) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
`ifdef TLC_PREEMPT_EN
    pre_drv = 1'b0;
    bus.preempt = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int g;
    bus.req = 4'b0000;
`ifdef TLC_PREEMPT_EN
    bus.preempt = 1'b0;
`endif

    // 1: reset values and 50 idle cycles
    do_reset();
    chk("rst_M", bus.light_M, LT_GRN);
    chk("rst_MT", bus.light_MT, LT_RED);
    chk("rst_S", bus.light_S, LT_RED);
    chk("rst_P", bus.light_P, LT_RED);
    chk("rst_phase", bus.phase, 2'd0);
    chk("rst_start", bus.phase_start, 1'b0);
    starts = 0;
    repeat (50) cyc(4'b0000);
    chk("idle_starts", starts, 0);
    chk("idle_M", bus.light_M, LT_GRN);

    // 2: single S request right after reset
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      cyc((c == 1) ? 4'b0100 : 4'b0000);
      chk("s2_M", bus.light_M, (c < 4) ? LT_GRN : (c < 7) ? LT_YEL : LT_RED);
    end
    chk("s2_S", bus.light_S, LT_GRN);
    chk("s2_start", bus.phase_start, 1'b1);
    chk("s2_phase", bus.phase, 2'd2);

    // 3a: S held, M pending -> max-out after 10 green cycles
    g = 1;
    for (int t = 0; t < 30; t++) begin
      cyc((t == 0) ? 4'b0101 : 4'b0100);
      if (bus.light_S != LT_GRN) break;
      g++;
    end
    chk("s3_maxout_len", g, 10);
    wait_start("s3_to_M");
    chk("s3_phase_M", bus.phase, 2'd0);
    cyc(4'b0100);
    wait_start("s3_to_S");
    chk("s3_phase_S", bus.phase, 2'd2);
    // 3b: S dropped at timer 5 -> gap-out after 6 green cycles
    g = 1;
    for (int t = 0; t < 30; t++) begin
      cyc((t == 0) ? 4'b0101 : (t < 5) ? 4'b0100 : 4'b0000);
      if (bus.light_S != LT_GRN) break;
      g++;
    end
    chk("s3_gapout_len", g, 6);

    // 4: round-robin 1,2,3 then rest in 3
    do_reset();
    p_yel_seen = 1'b0;
    cyc(4'b1110);
    wait_start("s4_a");
    chk("s4_first", bus.phase, 2'd1);
    wait_start("s4_b");
    chk("s4_second", bus.phase, 2'd2);
    wait_start("s4_c");
    chk("s4_third", bus.phase, 2'd3);
    starts = 0;
    repeat (40) cyc(4'b0000);
    chk("s4_rest_starts", starts, 0);
    chk("s4_rest_P", bus.light_P, LT_GRN);
    cyc(4'b0001);
    wait_start("s4_d");
    chk("s4_back_M", bus.phase, 2'd0);
    chk("s4_P_yellow_seen", p_yel_seen, 1'b1);

    // 5: asynchronous reset during S yellow
    do_reset();
    cyc(4'b0100);
    wait_start("s5_S");
    cyc(4'b0001);
    g = 0;
    while (bus.light_S != LT_YEL && g < 30) begin
      cyc(4'b0000);
      g++;
    end
    chk("s5_in_yellow", bus.light_S, LT_YEL);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_M", bus.light_M, LT_GRN);
    chk("s5_S", bus.light_S, LT_RED);
    chk("s5_phase", bus.phase, 2'd0);
    chk("s5_start", bus.phase_start, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    starts = 0;
    repeat (20) cyc(4'b0000);
    chk("s5_pend_cleared", starts, 0);

`ifdef TLC_PREEMPT_EN
    // 6: preemption from S green at timer 1
    do_reset();
    cyc(4'b0100);
    wait_start("s6_S");
    cyc(4'b0000);
    pre_drv = 1'b1;
    cyc(4'b0010);
    chk("s6_S_yellow", bus.light_S, LT_YEL);
    chk("s6_act", bus.preempt_act, 1'b1);
    wait_start("s6_M");
    chk("s6_phase_M", bus.phase, 2'd0);
    starts = 0;
    repeat (20) cyc(4'b0000);
    chk("s6_hold_starts", starts, 0);
    chk("s6_hold_M", bus.light_M, LT_GRN);
    pre_drv = 1'b0;
    wait_start("s6_MT");
    chk("s6_served_MT", bus.phase, 2'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
